// File: rtl/pixel_window_fetcher_pkg.sv
// rtl/pixel_window_fetcher_pkg.sv - shared types, register map and field positions for the pixel window fetcher
package pixel_window_fetcher_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    SETTLE,
    CHECK
  } fetch_state_e;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_XWIN   = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int EDGE_BIT = 30;
  localparam int TMO_BIT  = 31;

  localparam int ST_LEVEL_LSB = 0;
  localparam int ST_TMO_BIT   = 8;
  localparam int ST_BUSY_BIT  = 9;
  localparam int ST_Y_LSB     = 16;

  localparam int XWIN_LO_LSB = 0;
  localparam int XWIN_HI_LSB = 16;

  localparam int CTRL_PREFETCH_BIT = 0;
  localparam int CTRL_CLEAR_BIT    = 1;

endpackage

// File: rtl/pixel_window_fetcher_fifo.sv
// rtl/pixel_window_fetcher_fifo.sv - synchronous prefetch FIFO with flush, combinational head and level count
module pixel_fifo #(
  parameter int WIDTH = 43,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;

  assign head_data = mem_q[rd_ptr_q];
  assign full      = (level_q == FULL_LEVEL);
  assign empty     = (level_q == '0);
  assign level     = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/pixel_window_fetcher.sv
// rtl/pixel_window_fetcher.sv - Avalon-MM pixel fetcher: bus decode, registers, fetch FSM, retry counter, packer
module pixel_window_fetcher
  import pixel_window_fetcher_pkg::*;
#(
  parameter int COLOR_W       = 8,
  parameter int COORD_W       = 11,
  parameter int X_MAX         = 640,
  parameter int X_LO_DEF      = 6,
  parameter int X_HI_DEF      = 637,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int MAX_RETRY     = 1023
) (
  input  logic               csi_clk,
  input  logic               rsi_reset_n,
  input  logic [1:0]         avs_s0_address,
  input  logic               avs_s0_read,
  input  logic               avs_s0_write,
  input  logic [31:0]        avs_s0_writedata,
  output logic [31:0]        avs_s0_readdata,
  output logic               avs_s0_waitrequest,
  input  logic [COLOR_W-1:0] coe_c0_red,
  input  logic [COLOR_W-1:0] coe_c1_green,
  input  logic [COLOR_W-1:0] coe_c2_blue,
  input  logic               coe_c3_switchzero,
  output logic               coe_c4_requestclock,
  input  logic [COORD_W-1:0] coe_c5_x,
  input  logic [COORD_W-1:0] coe_c6_y
);

  localparam int FW       = 32 + COORD_W;
  localparam int LVL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int RETRY_W  = $clog2(MAX_RETRY + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [RETRY_W-1:0]  RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0]  RETRY_ONE   = RETRY_W'(1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
  localparam logic [COORD_W-1:0]  X_LAST      = COORD_W'(X_MAX);

  fetch_state_e        state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [RETRY_W-1:0]  retry_q, retry_d, retry_inc;
  logic [COORD_W-1:0]  x_lo_q, x_lo_d, x_hi_q, x_hi_d;
  logic [COORD_W-1:0]  last_y_q, last_y_d;
  logic                prefetch_en_q, prefetch_en_d;
  logic                timeout_q, timeout_d;

  logic             data_rd, wr_xwin, wr_ctrl, trigger;
  logic             push, pop, timeout_set, latch_y;
  logic [31:0]      push_word;
  logic [FW-1:0]    fifo_head;
  logic             fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic             unused_bits;

  assign data_rd            = avs_s0_read && (avs_s0_address == ADDR_DATA);
  assign wr_xwin            = avs_s0_write && (avs_s0_address == ADDR_XWIN);
  assign wr_ctrl            = avs_s0_write && (avs_s0_address == ADDR_CTRL);
  assign avs_s0_waitrequest = data_rd && fifo_empty;
  assign pop                = data_rd && !fifo_empty;
  assign coe_c4_requestclock = (state_q == PULSE);
  assign retry_inc          = retry_q + RETRY_ONE;
  assign trigger            = (data_rd && fifo_empty) || (prefetch_en_q && !fifo_full);
  assign unused_bits        = ^{avs_s0_writedata, fifo_head[FW-1:32]};

  pixel_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (csi_clk),
    .rst_n     (rsi_reset_n),
    .flush     (coe_c3_switchzero),
    .push      (push),
    .push_data ({coe_c6_y, push_word}),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    retry_d     = retry_q;
    push        = 1'b0;
    push_word   = '0;
    timeout_set = 1'b0;
    latch_y     = 1'b0;
    if (coe_c3_switchzero) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          retry_d = '0;
          if (trigger) state_d = PULSE;
        end
        PULSE: begin
          settle_d = SETTLE_LAST;
          state_d  = SETTLE;
        end
        SETTLE: begin
          if (settle_q == '0) state_d = CHECK;
          else                settle_d = settle_q - SETTLE_ONE;
        end
        CHECK: begin
          if (coe_c5_x == '0 || coe_c5_x > X_LAST) begin
            retry_d = retry_inc;
            if (retry_inc < RETRY_LIMIT) begin
              state_d = PULSE;
            end else begin
              push               = 1'b1;
              push_word[TMO_BIT] = 1'b1;
              timeout_set        = 1'b1;
              state_d            = IDLE;
            end
          end else begin
            push    = 1'b1;
            latch_y = 1'b1;
            state_d = IDLE;
            // Inverted window (x_lo > x_hi) never matches, so every active column is an edge.
            if (coe_c5_x >= x_lo_q && coe_c5_x <= x_hi_q)
              push_word[3*COLOR_W-1:0] = {coe_c0_red, coe_c1_green, coe_c2_blue};
            else
              push_word[EDGE_BIT] = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    x_lo_d        = x_lo_q;
    x_hi_d        = x_hi_q;
    prefetch_en_d = prefetch_en_q;
    timeout_d     = timeout_q;
    last_y_d      = latch_y ? coe_c6_y : last_y_q;
    if (wr_xwin) begin
      x_lo_d = avs_s0_writedata[XWIN_LO_LSB +: COORD_W];
      x_hi_d = avs_s0_writedata[XWIN_HI_LSB +: COORD_W];
    end
    if (wr_ctrl) begin
      prefetch_en_d = avs_s0_writedata[CTRL_PREFETCH_BIT];
      if (avs_s0_writedata[CTRL_CLEAR_BIT]) timeout_d = 1'b0;
    end
    if (timeout_set) timeout_d = 1'b1;
  end

  always_comb begin
    avs_s0_readdata = '0;
    if (avs_s0_read) begin
      case (avs_s0_address)
        ADDR_DATA:   if (!fifo_empty) avs_s0_readdata = fifo_head[31:0];
        ADDR_STATUS: begin
          avs_s0_readdata[ST_LEVEL_LSB +: 8]     = 8'(fifo_level);
          avs_s0_readdata[ST_TMO_BIT]            = timeout_q;
          avs_s0_readdata[ST_BUSY_BIT]           = (state_q != IDLE);
          avs_s0_readdata[ST_Y_LSB +: COORD_W]   = last_y_q;
        end
        ADDR_XWIN: begin
          avs_s0_readdata[XWIN_LO_LSB +: COORD_W] = x_lo_q;
          avs_s0_readdata[XWIN_HI_LSB +: COORD_W] = x_hi_q;
        end
        default:     avs_s0_readdata[CTRL_PREFETCH_BIT] = prefetch_en_q;
      endcase
    end
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state_q       <= IDLE;
      settle_q      <= '0;
      retry_q       <= '0;
      x_lo_q        <= COORD_W'(X_LO_DEF);
      x_hi_q        <= COORD_W'(X_HI_DEF);
      last_y_q      <= '0;
      prefetch_en_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      retry_q       <= retry_d;
      x_lo_q        <= x_lo_d;
      x_hi_q        <= x_hi_d;
      last_y_q      <= last_y_d;
      prefetch_en_q <= prefetch_en_d;
      timeout_q     <= timeout_d;
    end
  end

endmodule

// File: tb/tb_pixel_window_fetcher.sv
// tb/tb_pixel_window_fetcher.sv - directed bench with a camera model and an expected-word scoreboard
module tb_pixel_window_fetcher;

  localparam int X_MAX     = 640;
  localparam int MAX_RETRY = 8;

  logic        csi_clk = 1'b0;
  logic        rsi_reset_n = 1'b0;
  logic [1:0]  avs_s0_address = '0;
  logic        avs_s0_read = 1'b0;
  logic        avs_s0_write = 1'b0;
  logic [31:0] avs_s0_writedata = '0;
  logic [31:0] avs_s0_readdata;
  logic        avs_s0_waitrequest;
  logic        coe_c3_switchzero = 1'b0;
  logic        coe_c4_requestclock;
  logic [7:0]  cam_r = '0, cam_g = '0, cam_b = '0;
  logic [10:0] cam_x = '0, cam_y = '0;

  logic [7:0]  next_r = '0, next_g = '0, next_b = '0;
  logic [10:0] next_x = '0, next_y = '0;
  bit          auto_inc = 1'b0;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  logic [31:0] exp_q[$];
  int          m_retry = 0;
  logic [10:0] m_lo = 11'd6, m_hi = 11'd637, m_last_y = '0;
  logic        m_tmo = 1'b0;
  logic        req_prev = 1'b0;

  always #5 csi_clk = ~csi_clk;

  pixel_window_fetcher #(
    .COLOR_W(8), .COORD_W(11), .X_MAX(X_MAX), .X_LO_DEF(6), .X_HI_DEF(637),
    .FIFO_DEPTH(4), .SETTLE_CYCLES(1), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .csi_clk            (csi_clk),
    .rsi_reset_n        (rsi_reset_n),
    .avs_s0_address     (avs_s0_address),
    .avs_s0_read        (avs_s0_read),
    .avs_s0_write       (avs_s0_write),
    .avs_s0_writedata   (avs_s0_writedata),
    .avs_s0_readdata    (avs_s0_readdata),
    .avs_s0_waitrequest (avs_s0_waitrequest),
    .coe_c0_red         (cam_r),
    .coe_c1_green       (cam_g),
    .coe_c2_blue        (cam_b),
    .coe_c3_switchzero  (coe_c3_switchzero),
    .coe_c4_requestclock(coe_c4_requestclock),
    .coe_c5_x           (cam_x),
    .coe_c6_y           (cam_y)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Outcome of one camera sample, decided from the pixel rules alone.
  task automatic model_sample(input int x, input logic [10:0] y,
                              input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    if (x == 0 || x > X_MAX) begin
      m_retry++;
      if (m_retry == MAX_RETRY) begin
        exp_q.push_back(32'h8000_0000);
        m_tmo   = 1'b1;
        m_retry = 0;
      end
    end else begin
      m_retry  = 0;
      m_last_y = y;
      if (x >= int'(m_lo) && x <= int'(m_hi)) exp_q.push_back({8'h00, r, g, b});
      else                                    exp_q.push_back(32'h4000_0000);
    end
  endtask

  task automatic model_flush();
    exp_q.delete();
    m_retry = 0;
  endtask

  function automatic logic [31:0] status_exp(input int level, input logic busy);
    return {5'b0, m_last_y, 6'b0, busy, m_tmo, 8'(level)};
  endfunction

  // Camera: advances on each request pulse; the new pixel is what the next check sees.
  always @(negedge csi_clk) begin
    if (coe_c4_requestclock) begin
      pulses++;
      cam_x = next_x; cam_y = next_y; cam_r = next_r; cam_g = next_g; cam_b = next_b;
      model_sample(int'(next_x), next_y, next_r, next_g, next_b);
      if (auto_inc) next_b = next_b + 8'd1;
    end
  end

  always @(negedge csi_clk) begin
    if (rsi_reset_n) begin
      if (avs_s0_read && avs_s0_address == 2'd0 && !avs_s0_waitrequest) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL data_unexpected: got 0x%08h expected no word", avs_s0_readdata);
        end else begin
          check("data_word", avs_s0_readdata, exp_q.pop_front());
        end
      end
      if (avs_s0_write || (avs_s0_read && avs_s0_address != 2'd0))
        check("no_stall", {31'b0, avs_s0_waitrequest}, 32'h0);
      check("req_single_cycle", {31'b0, coe_c4_requestclock && req_prev}, 32'h0);
      req_prev = coe_c4_requestclock;
    end else begin
      req_prev = 1'b0;
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge csi_clk); #1;
    avs_s0_address = a; avs_s0_writedata = d; avs_s0_write = 1'b1;
    @(posedge csi_clk); #1;
    avs_s0_write = 1'b0;
    if (a == 2'd2) begin m_lo = d[10:0]; m_hi = d[26:16]; end
    if (a == 2'd3 && d[1]) m_tmo = 1'b0;
  endtask

  task automatic start_read(input logic [1:0] a);
    @(posedge csi_clk); #1;
    avs_s0_address = a; avs_s0_read = 1'b1;
  endtask

  task automatic finish_read(output logic [31:0] d, output int waits);
    waits = 0;
    forever begin
      @(negedge csi_clk);
      if (!avs_s0_waitrequest) break;
      waits++;
      if (waits > 300) begin
        checks++;
        errors++;
        $display("FAIL read_timeout: got %0d stalled cycles expected completion", waits);
        break;
      end
    end
    d = avs_s0_readdata;
    @(posedge csi_clk); #1;
    avs_s0_read = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output int waits);
    start_read(a);
    finish_read(d, waits);
  endtask

  task automatic set_pixel(input int x, input int y, input logic [7:0] r,
                           input logic [7:0] g, input logic [7:0] b);
    next_x = 11'(x); next_y = 11'(y); next_r = r; next_g = g; next_b = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int w, p0, n;

    repeat (3) @(posedge csi_clk);
    #1;
    check("rst_req", {31'b0, coe_c4_requestclock}, 32'h0);
    check("rst_wait", {31'b0, avs_s0_waitrequest}, 32'h0);
    check("rst_readdata", avs_s0_readdata, 32'h0);
    rsi_reset_n = 1'b1;
    bus_read(2'd1, d, w); check("rst_status", d, 32'h0);
    bus_read(2'd2, d, w); check("rst_xwin", d, 32'h027D_0006);
    bus_read(2'd3, d, w); check("rst_ctrl", d, 32'h0);

    // Single-shot fetch into an empty FIFO.
    set_pixel(100, 26, 8'h11, 8'h22, 8'h33);
    p0 = pulses;
    bus_read(2'd0, d, w);
    check("t1_word", d, 32'h0011_2233);
    check("t1_waits", 32'(w), 32'd4);
    check("t1_pulses", 32'(pulses - p0), 32'd1);
    bus_read(2'd1, d, w);
    check("t1_status", d, 32'h001A_0000);
    check("t1_status_model", d, status_exp(0, 1'b0));

    // Edge words and window boundaries.
    set_pixel(3, 27, 8'h44, 8'h55, 8'h66);
    bus_read(2'd0, d, w); check("t2_x3_edge", d, 32'h4000_0000);
    set_pixel(639, 28, 8'h44, 8'h55, 8'h66);
    bus_read(2'd0, d, w); check("t2_x639_edge", d, 32'h4000_0000);
    bus_read(2'd1, d, w); check("t2_status_y", d, 32'h001C_0000);
    bus_write(2'd2, 32'h00C8_0064);
    bus_read(2'd2, d, w); check("t2_xwin_rb", d, 32'h00C8_0064);
    set_pixel(150, 29, 8'hA1, 8'hB2, 8'hC3);
    bus_read(2'd0, d, w); check("t2_x150_pixel", d, 32'h00A1_B2C3);
    set_pixel(100, 29, 8'h01, 8'h02, 8'h03);
    bus_read(2'd0, d, w); check("t2_x100_lo_incl", d, 32'h0001_0203);
    set_pixel(200, 29, 8'h04, 8'h05, 8'h06);
    bus_read(2'd0, d, w); check("t2_x200_hi_incl", d, 32'h0004_0506);
    set_pixel(201, 29, 8'h07, 8'h08, 8'h09);
    bus_read(2'd0, d, w); check("t2_x201_edge", d, 32'h4000_0000);
    bus_write(2'd2, 32'h027D_0006);

    // Blanking held: retries then timeout word and sticky flag.
    set_pixel(0, 30, 8'h12, 8'h34, 8'h56);
    p0 = pulses;
    bus_read(2'd0, d, w);
    check("t3_tmo_word", d, 32'h8000_0000);
    check("t3_pulses", 32'(pulses - p0), 32'd8);
    check("t3_waits", 32'(w), 32'd25);
    bus_read(2'd1, d, w);
    check("t3_status_tmo", d, 32'h001D_0100);
    check("t3_status_model", d, status_exp(0, 1'b0));
    bus_write(2'd3, 32'h2);
    bus_read(2'd1, d, w);
    check("t3_status_clr", d, 32'h001D_0000);

    // Prefetch fills the FIFO, then back-to-back zero-wait reads.
    set_pixel(300, 40, 8'h01, 8'h02, 8'h10);
    auto_inc = 1'b1;
    p0 = pulses;
    bus_write(2'd3, 32'h1);
    repeat (20) @(posedge csi_clk);
    check("t4_pulses", 32'(pulses - p0), 32'd4);
    bus_read(2'd1, d, w);
    check("t4_status_full", d, 32'h0028_0004);
    check("t4_status_model", d, status_exp(4, 1'b0));
    @(posedge csi_clk); #1;
    avs_s0_address = 2'd0; avs_s0_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge csi_clk);
      check("t4_b2b_nowait", {31'b0, avs_s0_waitrequest}, 32'h0);
      if (i == 0) check("t4_first_word", avs_s0_readdata, 32'h0001_0210);
    end
    @(posedge csi_clk); #1;
    avs_s0_read = 1'b0;
    bus_write(2'd3, 32'h0);
    repeat (10) @(posedge csi_clk);

    // Flush while a fetch sits in SETTLE behind two queued words.
    #1 coe_c3_switchzero = 1'b1; model_flush();
    @(posedge csi_clk); #1 coe_c3_switchzero = 1'b0;
    bus_read(2'd1, d, w);
    check("t5_pre_level", {24'b0, d[7:0]}, 32'h0);
    p0 = pulses;
    bus_write(2'd3, 32'h1);
    n = 0;
    while (pulses < p0 + 3 && n < 100) begin @(posedge csi_clk); n++; end
    check("t5_third_pulse", 32'(pulses - p0), 32'd3);
    #1 coe_c3_switchzero = 1'b1; model_flush();
    repeat (4) begin
      @(negedge csi_clk);
      check("t5_sz_no_req", {31'b0, coe_c4_requestclock}, 32'h0);
    end
    bus_write(2'd3, 32'h0);
    bus_read(2'd1, d, w);
    check("t5_flushed_level", {24'b0, d[7:0]}, 32'h0);
    auto_inc = 1'b0;
    set_pixel(250, 41, 8'h05, 8'h06, 8'h07);
    start_read(2'd0);
    repeat (5) begin
      @(negedge csi_clk);
      check("t5_held_stall", {30'b0, avs_s0_waitrequest, coe_c4_requestclock}, 32'h2);
    end
    @(posedge csi_clk); #1 coe_c3_switchzero = 1'b0;
    p0 = pulses;
    finish_read(d, w);
    check("t5_release_word", d, 32'h0005_0607);
    check("t5_release_waits", 32'(w), 32'd4);
    check("t5_release_pulses", 32'(pulses - p0), 32'd1);

    // Asynchronous reset while the request pulse is high.
    bus_write(2'd2, 32'h0100_0010);
    set_pixel(120, 42, 8'h09, 8'h08, 8'h07);
    start_read(2'd0);
    n = 0;
    while (!coe_c4_requestclock && n < 20) begin @(posedge csi_clk); #1; n++; end
    check("t6_in_pulse", {31'b0, coe_c4_requestclock}, 32'h1);
    rsi_reset_n = 1'b0;
    avs_s0_read = 1'b0;
    model_flush();
    m_lo = 11'd6; m_hi = 11'd637; m_last_y = '0; m_tmo = 1'b0;
    #1;
    check("t6_req_drop", {31'b0, coe_c4_requestclock}, 32'h0);
    @(posedge csi_clk); #1;
    check("t6_rst_readdata", avs_s0_readdata, 32'h0);
    rsi_reset_n = 1'b1;
    bus_read(2'd2, d, w); check("t6_xwin_default", d, 32'h027D_0006);
    bus_read(2'd1, d, w); check("t6_status_default", d, 32'h0);
    bus_read(2'd3, d, w); check("t6_ctrl_default", d, 32'h0);
    p0 = pulses;
    bus_read(2'd0, d, w);
    check("t6_fetch_word", d, 32'h0009_0807);
    check("t6_fetch_waits", 32'(w), 32'd4);
    check("t6_fetch_pulses", 32'(pulses - p0), 32'd1);
    check("t6_model_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
